// File: rtl/rf_dribbler.sv
// Stack-cache dribbler: spills the bottom register-file entry to memory when the
// cache is too full and fills the entry below bottom from memory when it is too empty.
module rf_dribbler #(
  parameter int HI_MARK = 48,
  parameter int LO_MARK = 8,
  parameter int SCNT_W  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  optop,
  input  logic        dribble_en,
  input  logic        sc_bot_load,
  input  logic [31:0] sc_bot_addr_in,
  output logic [5:0]  add_c,
  input  logic [31:0] do_c,
  output logic [5:0]  add_e,
  output logic [31:0] di_e,
  output logic        we_e,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [5:0]  bottom,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SP_RD  = 3'd1,
    SP_REQ = 3'd2,
    FL_REQ = 3'd3,
    FL_WR  = 3'd4
  } state_t;

  localparam logic [5:0]        HI6      = 6'(HI_MARK);
  localparam logic [5:0]        LO6      = 6'(LO_MARK);
  localparam logic [SCNT_W-1:0] SCNT_MAX = {SCNT_W{1'b1}};

  state_t            state, next_state;
  logic [5:0]        occ;
  logic [31:0]       bot_addr;
  logic [SCNT_W-1:0] spilled;
  logic              start_spill, start_fill;

  // occupancy wraps mod 64 with the 6-bit subtraction
  assign occ         = optop - bottom;
  assign start_spill = dribble_en && (occ > HI6);
  assign start_fill  = dribble_en && (occ < LO6) && (spilled != '0);

  assign we_e = (state == FL_WR);
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (sc_bot_load)      next_state = IDLE;
        else if (start_spill) next_state = SP_RD;
        else if (start_fill)  next_state = FL_REQ;
      end
      SP_RD:   next_state = SP_REQ;
      SP_REQ:  if (mem_ack) next_state = IDLE;
      FL_REQ:  if (mem_ack) next_state = FL_WR;
      FL_WR:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // add_c is registered on the way into SP_RD so do_c is valid during SP_RD
  always_ff @(posedge clk) begin
    if (reset) begin
      bottom    <= '0;
      bot_addr  <= '0;
      spilled   <= '0;
      add_c     <= '0;
      add_e     <= '0;
      di_e      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sc_bot_load) begin
            bottom   <= optop;
            bot_addr <= sc_bot_addr_in;
            spilled  <= '0;
          end else if (start_spill) begin
            add_c <= bottom;
          end else if (start_fill) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= bot_addr + 32'd4;
          end
        end
        SP_RD: begin
          mem_wdata <= do_c;
          mem_addr  <= bot_addr;
          mem_we    <= 1'b1;
          mem_req   <= 1'b1;
        end
        SP_REQ: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            bottom   <= bottom + 6'd1;
            bot_addr <= bot_addr - 32'd4;
            if (spilled != SCNT_MAX) spilled <= spilled + 1'b1;
          end
        end
        FL_REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            di_e    <= mem_rdata;
            add_e   <= bottom - 6'd1;
          end
        end
        FL_WR: begin
          bottom   <= bottom - 6'd1;
          bot_addr <= bot_addr + 32'd4;
          if (spilled != '0) spilled <= spilled - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_dribbler.sv
// Directed bench for rf_dribbler: register file and memory are modelled here,
// inputs change on the falling edge and outputs are checked on the falling edge.
module tb_rf_dribbler;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  optop;
  logic        dribble_en;
  logic        sc_bot_load;
  logic [31:0] sc_bot_addr_in;
  logic [5:0]  add_c;
  logic [31:0] do_c;
  logic [5:0]  add_e;
  logic [31:0] di_e;
  logic        we_e;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [5:0]  bottom;
  logic        busy;

  logic [31:0] rf [64];
  int tests = 0;
  int fails = 0;

  assign do_c = rf[add_c];

  always #5 clk = ~clk;

  rf_dribbler dut (
    .clk(clk), .reset(reset), .optop(optop), .dribble_en(dribble_en),
    .sc_bot_load(sc_bot_load), .sc_bot_addr_in(sc_bot_addr_in),
    .add_c(add_c), .do_c(do_c), .add_e(add_e), .di_e(di_e), .we_e(we_e),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bottom(bottom), .busy(busy)
  );

  task automatic wait_req(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_req && n < 20);
    tests++;
    if (mem_req !== 1'b1) begin
      fails++;
      $display("FAIL req_timeout: mem_req=%b after %0d cycles, expected 1", mem_req, n);
    end
  endtask

  task automatic load_bottom(input logic [5:0] top, input logic [31:0] addr);
    dribble_en = 1'b0;
    optop = top;
    sc_bot_addr_in = addr;
    sc_bot_load = 1'b1;
    @(negedge clk);
    sc_bot_load = 1'b0;
    tests++;
    if (bottom !== top) begin
      fails++;
      $display("FAIL load_bottom: bottom=%0d, expected %0d", bottom, top);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({mem_req, mem_we, we_e, busy} !== 4'b0) begin
      fails++;
      $display("FAIL reset_ctrl: req/we/we_e/busy=%b, expected 0000", {mem_req, mem_we, we_e, busy});
    end
    tests++;
    if ({add_c, add_e, bottom} !== 18'd0) begin
      fails++;
      $display("FAIL reset_idx: add_c=%0d add_e=%0d bottom=%0d, expected 0", add_c, add_e, bottom);
    end
    tests++;
    if ({di_e, mem_addr, mem_wdata} !== 96'd0) begin
      fails++;
      $display("FAIL reset_data: di_e=%h addr=%h wdata=%h, expected 0", di_e, mem_addr, mem_wdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_load;
    int seen;
    dribble_en = 1'b1;
    optop = 6'd5;
    sc_bot_addr_in = 32'h1000;
    sc_bot_load = 1'b1;
    @(negedge clk);
    sc_bot_load = 1'b0;
    tests++;
    if (bottom !== 6'd5 || busy !== 1'b0) begin
      fails++;
      $display("FAIL load: bottom=%0d busy=%b, expected 5 0", bottom, busy);
    end
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_req !== 1'b0) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL load_quiet: mem_req high %0d cycles, expected 0", seen);
    end
  endtask

  task automatic test_spill;
    int n, drop;
    load_bottom(6'd0, 32'h1000);
    rf[0] = 32'hCAFE0001;
    optop = 6'd49;
    dribble_en = 1'b1;
    wait_req(n);
    tests++;
    if (n != 2) begin
      fails++;
      $display("FAIL spill_latency: %0d cycles, expected 2", n);
    end
    tests++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h1000 || mem_wdata !== 32'hCAFE0001) begin
      fails++;
      $display("FAIL spill_req: we=%b addr=%h wdata=%h, expected 1 00001000 cafe0001", mem_we, mem_addr, mem_wdata);
    end
    drop = 0;
    repeat (3) begin
      @(negedge clk);
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h1000 || mem_wdata !== 32'hCAFE0001) drop++;
    end
    tests++;
    if (drop != 0) begin
      fails++;
      $display("FAIL spill_hold: request changed in %0d cycles, expected 0", drop);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    dribble_en = 1'b0;
    tests++;
    if (mem_req !== 1'b0 || bottom !== 6'd1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL spill_done: req=%b bottom=%0d busy=%b, expected 0 1 0", mem_req, bottom, busy);
    end
  endtask

  task automatic test_fill;
    int n, seen;
    optop = 6'd3;
    dribble_en = 1'b1;
    wait_req(n);
    tests++;
    if (n != 1 || mem_we !== 1'b0 || mem_addr !== 32'h1000) begin
      fails++;
      $display("FAIL fill_req: lat=%0d we=%b addr=%h, expected 1 0 00001000", n, mem_we, mem_addr);
    end
    mem_rdata = 32'h12345678;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    tests++;
    if (we_e !== 1'b1 || add_e !== 6'd0 || di_e !== 32'h12345678 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL fill_write: we_e=%b add_e=%0d di_e=%h req=%b, expected 1 0 12345678 0", we_e, add_e, di_e, mem_req);
    end
    @(negedge clk);
    tests++;
    if (we_e !== 1'b0 || bottom !== 6'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL fill_done: we_e=%b bottom=%0d busy=%b, expected 0 0 0", we_e, bottom, busy);
    end
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_req !== 1'b0 || busy !== 1'b0) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL fill_empty_count: active %0d cycles with nothing spilled, expected 0", seen);
    end
    dribble_en = 1'b0;
  endtask

  task automatic test_wrap;
    int n;
    load_bottom(6'd63, 32'h2000);
    rf[63] = 32'hA5A50063;
    optop = 6'd48;
    dribble_en = 1'b1;
    wait_req(n);
    tests++;
    if (add_c !== 6'd63 || mem_wdata !== 32'hA5A50063 || mem_addr !== 32'h2000) begin
      fails++;
      $display("FAIL wrap_spill: add_c=%0d wdata=%h addr=%h, expected 63 a5a50063 00002000", add_c, mem_wdata, mem_addr);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    dribble_en = 1'b0;
    tests++;
    if (bottom !== 6'd0) begin
      fails++;
      $display("FAIL wrap_bottom_up: bottom=%0d, expected 0", bottom);
    end
    optop = 6'd2;
    dribble_en = 1'b1;
    wait_req(n);
    tests++;
    if (mem_addr !== 32'h2000 || mem_we !== 1'b0) begin
      fails++;
      $display("FAIL wrap_fill_req: addr=%h we=%b, expected 00002000 0", mem_addr, mem_we);
    end
    mem_rdata = 32'hBEEF0063;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    tests++;
    if (we_e !== 1'b1 || add_e !== 6'd63 || di_e !== 32'hBEEF0063) begin
      fails++;
      $display("FAIL wrap_fill_write: we_e=%b add_e=%0d di_e=%h, expected 1 63 beef0063", we_e, add_e, di_e);
    end
    @(negedge clk);
    dribble_en = 1'b0;
    tests++;
    if (bottom !== 6'd63) begin
      fails++;
      $display("FAIL wrap_bottom_down: bottom=%0d, expected 63", bottom);
    end
  endtask

  task automatic test_dribble_drop;
    int n, drop, seen;
    load_bottom(6'd10, 32'h3000);
    rf[10] = 32'h55AA0010;
    optop = 6'd60;
    dribble_en = 1'b1;
    wait_req(n);
    dribble_en = 1'b0;
    drop = 0;
    repeat (2) begin
      @(negedge clk);
      if (mem_req !== 1'b1 || mem_wdata !== 32'h55AA0010) drop++;
    end
    tests++;
    if (drop != 0) begin
      fails++;
      $display("FAIL drop_hold: request lost in %0d cycles, expected 0", drop);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    tests++;
    if (bottom !== 6'd11 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL drop_done: bottom=%0d req=%b, expected 11 0", bottom, mem_req);
    end
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_req !== 1'b0 || busy !== 1'b0) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL drop_idle: active %0d cycles with dribble_en low, expected 0", seen);
    end
  endtask

  task automatic test_reset_mid_fill;
    int n, seen;
    optop = 6'd13;
    dribble_en = 1'b1;
    wait_req(n);
    tests++;
    if (mem_we !== 1'b0 || mem_addr !== 32'h3000) begin
      fails++;
      $display("FAIL rst_fill_req: we=%b addr=%h, expected 0 00003000", mem_we, mem_addr);
    end
    reset = 1'b1;
    dribble_en = 1'b0;
    @(negedge clk);
    tests++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || we_e !== 1'b0 || bottom !== 6'd0) begin
      fails++;
      $display("FAIL rst_fill_drop: req=%b busy=%b we_e=%b bottom=%0d, expected 0 0 0 0", mem_req, busy, we_e, bottom);
    end
    reset = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (we_e !== 1'b0 || mem_req !== 1'b0) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL rst_fill_quiet: activity in %0d cycles after reset, expected 0", seen);
    end
  endtask

  task automatic test_busy_load;
    int n, seen;
    load_bottom(6'd20, 32'h4000);
    optop = 6'd22;
    dribble_en = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_req !== 1'b0 || busy !== 1'b0) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL no_fill_zero: active %0d cycles, expected 0", seen);
    end
    rf[20] = 32'h0BAD0020;
    optop = 6'd5;
    wait_req(n);
    sc_bot_addr_in = 32'hDEAD0000;
    sc_bot_load = 1'b1;
    @(negedge clk);
    sc_bot_load = 1'b0;
    tests++;
    if (bottom !== 6'd20 || mem_addr !== 32'h4000 || busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_load_ignored: bottom=%0d addr=%h busy=%b, expected 20 00004000 1", bottom, mem_addr, busy);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    dribble_en = 1'b0;
    tests++;
    if (bottom !== 6'd21) begin
      fails++;
      $display("FAIL busy_load_spill: bottom=%0d, expected 21", bottom);
    end
    optop = 6'd22;
    dribble_en = 1'b1;
    wait_req(n);
    tests++;
    if (mem_addr !== 32'h4000) begin
      fails++;
      $display("FAIL busy_load_addr: addr=%h, expected 00004000", mem_addr);
    end
    mem_rdata = 32'h00000001;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    dribble_en = 1'b0;
    tests++;
    if (bottom !== 6'd20 || add_e !== 6'd20) begin
      fails++;
      $display("FAIL busy_load_fill: bottom=%0d add_e=%0d, expected 20 20", bottom, add_e);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rf[i] = 32'h0;
    reset = 1'b1;
    optop = 6'd0;
    dribble_en = 1'b0;
    sc_bot_load = 1'b0;
    sc_bot_addr_in = 32'h0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    test_reset;
    test_load;
    test_spill;
    test_fill;
    test_wrap;
    test_dribble_drop;
    test_reset_mid_fill;
    test_busy_load;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
